// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA/DVI raster timing generator. Free-running pixel (h) and
//   line (v) counters advance on each pixel tick; their decode (syncs,
//   active-video, coordinates, line/frame markers) is registered once and then
//   shifted through DELAY further pixel-tick stages so the whole bundle can be
//   aligned with a downstream pixel pipeline. Total latency is 1+DELAY ticks.
//   Line/frame order: sync, back porch, active, front porch.
//
// Ports
//   i_Clk          in   system clock
//   i_Rst_n        in   asynchronous active-low reset
//   i_Pix_En       in   pixel tick; counters and pipeline advance only when high
//   o_HSync        out  horizontal sync, active level H_SYNC_POL
//   o_VSync        out  vertical sync, active level V_SYNC_POL
//   o_Valid        out  active-video region
//   o_X, o_Y       out  active-video coordinates, 0 outside active video
//   o_Line_Start   out  one pixel period at h=0 of every line
//   o_Frame_Start  out  one pixel period at h=0, v=0
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 12,
    parameter int DELAY      = 0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Pix_En,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Valid,
    output logic [CNT_W-1:0] o_X,
    output logic [CNT_W-1:0] o_Y,
    output logic             o_Line_Start,
    output logic             o_Frame_Start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_FIRST  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_VIS_FIRST  = CNT_W'(V_SYNC + V_BP);
    // Inclusive upper bounds: the exclusive end may equal H_TOTAL when the
    // front porch is zero, which is not guaranteed to fit in CNT_W.
    localparam logic [CNT_W-1:0] H_VIS_LAST   = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST   = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             valid;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             line_start;
        logic             frame_start;
    } stage_t;

    localparam stage_t STAGE_RST = '{
        hsync:       ~H_SYNC_POL,
        vsync:       ~V_SYNC_POL,
        valid:       1'b0,
        x:           '0,
        y:           '0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    stage_t           dec;
    stage_t           pipe [DELAY+1];

    // Raster counters
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_Pix_En) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Decode of the current counter position
    always_comb begin
        logic sync_h;
        logic sync_v;
        logic vis_h;
        logic vis_v;

        sync_h = (h_cnt < H_SYNC_END);
        sync_v = (v_cnt < V_SYNC_END);
        vis_h  = (h_cnt >= H_VIS_FIRST) && (h_cnt <= H_VIS_LAST);
        vis_v  = (v_cnt >= V_VIS_FIRST) && (v_cnt <= V_VIS_LAST);

        dec             = STAGE_RST;
        dec.hsync       = sync_h ? H_SYNC_POL : ~H_SYNC_POL;
        dec.vsync       = sync_v ? V_SYNC_POL : ~V_SYNC_POL;
        dec.valid       = vis_h && vis_v;
        dec.x           = dec.valid ? (h_cnt - H_VIS_FIRST) : '0;
        dec.y           = dec.valid ? (v_cnt - V_VIS_FIRST) : '0;
        dec.line_start  = (h_cnt == '0);
        dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage 0 captures the decode; stages 1..DELAY shift the whole bundle
    // together so every output sees the same latency.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe[i] <= STAGE_RST;
            end
        end else if (i_Pix_En) begin
            pipe[0] <= dec;
            for (int i = 1; i <= DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign o_HSync       = pipe[DELAY].hsync;
    assign o_VSync       = pipe[DELAY].vsync;
    assign o_Valid       = pipe[DELAY].valid;
    assign o_X           = pipe[DELAY].x;
    assign o_Y           = pipe[DELAY].y;
    assign o_Line_Start  = pipe[DELAY].line_start;
    assign o_Frame_Start = pipe[DELAY].frame_start;

endmodule
